// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the five-stage pipeline control blocks.
//   REG_W    : width of a register-specifier field (rs/rt/rd)
//   CTRL_W   : width of the flush-window down-counter
//   REG_ZERO : register $zero, which never creates a dependency
//   state_e  : hazard controller FSM states
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_W  = 5;
    localparam int CTRL_W = 3;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous, active-high reset (clears the count)
//   inc   : count one event on this edge
//   count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples the pre-edge value, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller: detects load-use hazards between the load in EX
// and the instruction in ID, sequences branch flushes, and keeps saturating
// stall/flush statistics.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   inIDEXMemR     : load in EX
//   inIDEXRt       : load destination register
//   inIFIDRs/Rt    : source fields of the instruction in ID
//   inIFIDUsesRt   : instruction in ID actually reads rt
//   inBranchTaken  : taken-branch pulse from MEM
//   outPCWrite     : PC write enable
//   outIFIDWrite   : IF/ID write enable
//   outBubble      : zero ID/EX control bits on the next edge
//   outFlush       : clear IF/ID, ID/EX and EX/MEM control bits
//   outStallCnt    : load-use stalls seen (saturating)
//   outFlushCnt    : taken branches seen (saturating)
//   outBusy        : FSM is in STALL or FLUSH
// ---------------------------------------------------------------------------
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inIDEXMemR,
    input  logic [REG_W-1:0] inIDEXRt,
    input  logic [REG_W-1:0] inIFIDRs,
    input  logic [REG_W-1:0] inIFIDRt,
    input  logic             inIFIDUsesRt,
    input  logic             inBranchTaken,
    output logic             outPCWrite,
    output logic             outIFIDWrite,
    output logic             outBubble,
    output logic             outFlush,
    output logic [CNT_W-1:0] outStallCnt,
    output logic [CNT_W-1:0] outFlushCnt,
    output logic             outBusy
);

    // The pulse cycle itself is flushed combinationally, so the FLUSH state
    // covers the remaining FLUSH_CYCLES cycles: counter runs FLUSH_CYCLES-1..0.
    localparam logic [CTRL_W-1:0] FLUSH_RELOAD = CTRL_W'(FLUSH_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] fcnt_q, fcnt_d;
    logic              lu;

    // rt only matters when the decoded instruction reads it; $zero never hazards.
    assign lu = inIDEXMemR
              & (inIDEXRt != REG_ZERO)
              & ((inIDEXRt == inIFIDRs) | (inIFIDUsesRt & (inIDEXRt == inIFIDRt)));

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (inBranchTaken) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end else if (lu) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                // A load-use here is impossible (bubble cleared MemRead); if it
                // shows up anyway, IDLE re-evaluates it next cycle.
                if (inBranchTaken) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_RELOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (inBranchTaken) begin
                    fcnt_d = FLUSH_RELOAD;
                end else if (fcnt_q != '0) begin
                    fcnt_d = fcnt_q - 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Flush wins over stall: the instruction that would stall is being discarded.
    assign outFlush     = (state_q == FLUSH) | inBranchTaken;
    assign outBubble    = lu & ~outFlush;
    assign outPCWrite   = ~outBubble;
    assign outIFIDWrite = ~outBubble;
    assign outBusy      = (state_q != IDLE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (outBubble),
        .count (outStallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (inBranchTaken),
        .count (outFlushCnt)
    );

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage datapath. It consumes the registered fields of the ID/EX stage register and the IF/ID instruction fields. It produces the write-enable, bubble and flush controls that drive PC, IF/ID and ID/EX. It also keeps saturating stall and flush statistics for debug.

## Interface
Parameters:
- FLUSH_CYCLES, 2: cycles flush is held after a taken branch (1..7).
- CNT_W, 16: width of statistics counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- inIDEXMemR  in  1  ID/EX MemRead (load in EX).
- inIDEXRt  in  5  ID/EX destination field of the load (rt).
- inIFIDRs  in  5  IF/ID rs field.
- inIFIDRt  in  5  IF/ID rt field.
- inIFIDUsesRt  in  1  decoded instruction in ID reads rt (R-type, store, branch).
- inBranchTaken  in  1  branch resolved taken, one-cycle pulse from MEM.
- outPCWrite  out  1  PC write enable.
- outIFIDWrite  out  1  IF/ID write enable.
- outBubble  out  1  force all ID/EX control bits to 0 on next edge.
- outFlush  out  1  clear IF/ID, ID/EX and EX/MEM control bits.
- outStallCnt  out  CNT_W  load-use stalls seen, saturating.
- outFlushCnt  out  CNT_W  taken branches seen, saturating.
- outBusy  out  1  FSM not in IDLE.

## Operation
- Load-use hazard (combinational): lu = inIDEXMemR & (inIDEXRt != 0) & ((inIDEXRt == inIFIDRs) | (inIFIDUsesRt & inIDEXRt == inIFIDRt)).
- FSM states: IDLE, STALL, FLUSH.
  - IDLE: if inBranchTaken, go to FLUSH and load the flush counter with FLUSH_CYCLES-1. Else if lu, go to STALL. Else stay in IDLE.
  - STALL: lasts exactly one cycle. If inBranchTaken, go to FLUSH. Else go to IDLE. A second load-use in STALL cannot occur, because the bubble cleared MemRead. If lu is seen anyway, return to IDLE and re-evaluate.
  - FLUSH: while the counter is nonzero, decrement it and stay. At zero, go to IDLE. inBranchTaken in FLUSH reloads the counter to FLUSH_CYCLES-1.
- Outputs:
  - outFlush = 1 in FLUSH, and combinationally in any state when inBranchTaken = 1.
  - outBubble = lu & ~outFlush. Flush has priority over stall.
  - outPCWrite = outIFIDWrite = ~outBubble. They stay 1 during flush so the fetch redirect is taken.
  - outBusy = (state != IDLE).
- Counters:
  - outStallCnt increments on every edge where outBubble = 1.
  - outFlushCnt increments on every edge where inBranchTaken = 1.
  - Both saturate at all-ones, with no wrap.
- The registers are the FSM state, the 3-bit flush counter and the two statistics counters. Everything else is combinational.

## Timing
- Reset (asynchronous, immediate): state = IDLE, flush counter = 0, outStallCnt = outFlushCnt = 0.
  - During reset, outPCWrite = outIFIDWrite = 1, outBubble = outFlush = outBusy = 0, provided inBranchTaken and lu are 0.
- Load-use: bubble is asserted in the same cycle lu is seen, with zero latency. PC and IF/ID hold for exactly 1 edge. The dependent instruction enters EX one cycle late.
- Taken branch at edge N: outFlush is high from the cycle of the pulse through FLUSH_CYCLES further cycles. The FSM returns to IDLE after the last flush cycle.
- lu and inBranchTaken high together: only flush is asserted, no bubble, and outStallCnt does not increment.
- Reset asserted mid-FLUSH or mid-STALL: the sequence is abandoned immediately. No residual flush after deassertion.

## Structure
- Shared package pipe_pkg:
  - state enum {IDLE, STALL, FLUSH}
  - REG_ZERO = 5'd0
  - field widths REG_W = 5 and CTRL_W
- Single sub-module sat_counter (parameter W; ports clk, rst, inc, count). It is instantiated twice for the statistics.
- The FSM and the hazard compare stay in hazard_unit.

## Test plan
- Reset: assert rst mid-run with a nonzero stall count -> counters read 0 and outBusy = 0 immediately, before the next clk edge.
- Load-use: inIDEXMemR = 1, inIDEXRt = 8, inIFIDRs = 8 -> outBubble = 1, outPCWrite = 0 for 1 cycle, outStallCnt = 1. Repeat with inIDEXRt = 0 -> no stall.
- rt dependency gating: inIDEXRt = 9, inIFIDRt = 9, inIFIDUsesRt = 0 -> no stall. With inIFIDUsesRt = 1 -> stall.
- Branch flush: single inBranchTaken pulse with FLUSH_CYCLES = 2 -> outFlush high for 3 consecutive cycles, then IDLE, outFlushCnt = 1.
- Simultaneous events: lu and inBranchTaken in the same cycle -> outFlush = 1, outBubble = 0, outPCWrite = 1, outStallCnt unchanged. A second branch pulse in FLUSH -> flush window extended.
- Saturation: CNT_W = 4, 20 load-use events -> outStallCnt holds 15.
